// File: rtl/dcpl_ctrl_seq_if.sv
// Decouple-control bundle between host/shell logic (master) and dcpl_ctrl_seq (slave).
interface dcpl_ctrl_seq_if #(
  parameter int CNT_BITS = 8
);
  logic                dcpl_req;
  logic                rlse_req;
  logic                issue;
  logic                cmpl;
  logic                block_new;
  logic                decouple;
  logic                dcpl_done;
  logic                busy;
  logic                timeout_err;
  logic                cnt_ovf;
  logic [CNT_BITS-1:0] outstanding;

  modport master (
    output dcpl_req, rlse_req, issue, cmpl,
    input  block_new, decouple, dcpl_done, busy, timeout_err, cnt_ovf, outstanding
  );

  modport slave (
    input  dcpl_req, rlse_req, issue, cmpl,
    output block_new, decouple, dcpl_done, busy, timeout_err, cnt_ovf, outstanding
  );
endinterface

// File: rtl/dcpl_ctrl_seq.sv
// Per-region decouple sequencer: block new traffic, drain in-flight work (bounded), decouple, settle on release.
// Outputs decode from registered state; dcpl_req to decouple is 2 cycles minimum, release takes SETTLE_CYCLES+1.
module dcpl_ctrl_seq #(
  parameter int CNT_BITS       = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic            aclk,
  input  logic            areset,
  dcpl_ctrl_seq_if.slave  ctl
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DCPL, S_RLSE} state_e;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LOAD = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [SW-1:0] SET_LOAD = (SETTLE_CYCLES > 0) ? SW'(SETTLE_CYCLES - 1) : '0;

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d, cnt_upd;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [SW-1:0]       set_q, set_d;
  logic                terr_q, terr_d;
  logic                ovf_q, ovf_d;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      set_q   <= '0;
      terr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      set_q   <= set_d;
      terr_q  <= terr_d;
      ovf_q   <= ovf_d;
    end
  end

  // In-flight tracking runs in every state; saturates high, never wraps below zero.
  always_comb begin
    cnt_upd = cnt_q;
    ovf_d   = ovf_q;
    if (ctl.issue && !ctl.cmpl) begin
      if (cnt_q == '1) ovf_d = 1'b1;
      else             cnt_upd = cnt_q + CNT_BITS'(1);
    end else if (ctl.cmpl && !ctl.issue && (cnt_q != '0)) begin
      cnt_upd = cnt_q - CNT_BITS'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    set_d   = set_q;
    terr_d  = terr_q;
    unique case (state_q)
      S_IDLE: begin
        if (ctl.dcpl_req) begin
          state_d = S_DRAIN;
          tmr_d   = TMR_LOAD;
          terr_d  = 1'b0;
        end
      end
      S_DRAIN: begin
        // A late issue racing block_new keeps us draining rather than being wiped by the clear.
        if ((cnt_q == '0) && (cnt_upd == '0)) begin
          state_d = S_DCPL;
        end else if ((TIMEOUT_CYCLES != 0) && (tmr_q == '0)) begin
          state_d = S_DCPL;
          terr_d  = 1'b1;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_DCPL: begin
        if (ctl.rlse_req) begin
          state_d = S_RLSE;
          set_d   = SET_LOAD;
        end
      end
      S_RLSE: begin
        if (set_q == '0) state_d = S_IDLE;
        else             set_d   = set_q - SW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The region is reset during reconfiguration, so its count restarts from zero.
  always_comb begin
    cnt_d = cnt_upd;
    if ((state_d == S_DCPL) && (state_q != S_DCPL)) cnt_d = '0;
  end

  always_comb begin
    ctl.block_new   = (state_q != S_IDLE);
    ctl.decouple    = (state_q == S_DCPL) || (state_q == S_RLSE);
    ctl.dcpl_done   = (state_q == S_DCPL);
    ctl.busy        = (state_q == S_DRAIN) || (state_q == S_RLSE);
    ctl.timeout_err = terr_q;
    ctl.cnt_ovf     = ovf_q;
    ctl.outstanding = cnt_q;
  end

endmodule

// File: tb/tb_dcpl_ctrl_seq.sv
// Directed bench: vector table on a 2-bit-counter instance, hand sequences on an 8-bit instance.
module tb_dcpl_ctrl_seq;

  logic aclk = 1'b0;
  logic areset;
  int   nerr = 0;
  int   nchk = 0;

  always #5 aclk = ~aclk;

  dcpl_ctrl_seq_if #(.CNT_BITS(8)) ifa ();
  dcpl_ctrl_seq_if #(.CNT_BITS(2)) ifb ();

  dcpl_ctrl_seq #(.CNT_BITS(8), .TIMEOUT_CYCLES(16), .SETTLE_CYCLES(4)) dut_a (
    .aclk(aclk), .areset(areset), .ctl(ifa.slave));
  dcpl_ctrl_seq #(.CNT_BITS(2), .TIMEOUT_CYCLES(16), .SETTLE_CYCLES(4)) dut_b (
    .aclk(aclk), .areset(areset), .ctl(ifb.slave));

  typedef struct {
    logic [3:0] in;   // {dcpl_req, rlse_req, issue, cmpl}
    logic [5:0] flg;  // {block_new, decouple, dcpl_done, busy, timeout_err, cnt_ovf}
    logic [1:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] in, input logic [5:0] flg, input logic [1:0] cnt);
    vec_t v;
    v.in = in; v.flg = flg; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] fa();
    return {ifa.block_new, ifa.decouple, ifa.dcpl_done, ifa.busy, ifa.timeout_err, ifa.cnt_ovf};
  endfunction

  function automatic logic [5:0] fb();
    return {ifb.block_new, ifb.decouple, ifb.dcpl_done, ifb.busy, ifb.timeout_err, ifb.cnt_ovf};
  endfunction

  task automatic a_release_to_idle(input string nm);
    ifa.rlse_req = 1'b1;
    tick();
    ifa.rlse_req = 1'b0;
    repeat (4) tick();
    chk(nm, {2'b0, fa()} & 8'h3C, 8'h00);
  endtask

  initial begin
    areset = 1'b1;
    {ifa.dcpl_req, ifa.rlse_req, ifa.issue, ifa.cmpl} = 4'b0;
    {ifb.dcpl_req, ifb.rlse_req, ifb.issue, ifb.cmpl} = 4'b0;
    repeat (3) tick();
    chk("rst_a_flags", {2'b0, fa()}, 8'h00);
    chk("rst_a_cnt", ifa.outstanding, 8'd0);
    chk("rst_b_flags", {2'b0, fb()}, 8'h00);
    areset = 1'b0;

    // Counter corners and request handling on the 2-bit instance.
    add(4'b0000, 6'b000000, 2'd0);
    add(4'b0010, 6'b000000, 2'd1);
    add(4'b0010, 6'b000000, 2'd2);
    add(4'b0010, 6'b000000, 2'd3);
    add(4'b0010, 6'b000001, 2'd3);
    add(4'b0011, 6'b000001, 2'd3);
    add(4'b0001, 6'b000001, 2'd2);
    add(4'b0001, 6'b000001, 2'd1);
    add(4'b0001, 6'b000001, 2'd0);
    add(4'b0001, 6'b000001, 2'd0);
    add(4'b0100, 6'b000001, 2'd0);
    add(4'b1100, 6'b100101, 2'd0);
    add(4'b0000, 6'b111001, 2'd0);
    add(4'b1000, 6'b111001, 2'd0);
    add(4'b0100, 6'b110101, 2'd0);
    add(4'b0000, 6'b110101, 2'd0);
    add(4'b1000, 6'b110101, 2'd0);
    add(4'b0000, 6'b110101, 2'd0);
    add(4'b0000, 6'b000001, 2'd0);

    for (int k = 0; k < tbl.size(); k++) begin
      {ifb.dcpl_req, ifb.rlse_req, ifb.issue, ifb.cmpl} = tbl[k].in;
      tick();
      chk($sformatf("vec%0d_flags", k), {2'b0, fb()}, {2'b0, tbl[k].flg});
      chk($sformatf("vec%0d_cnt", k), {6'b0, ifb.outstanding}, {6'b0, tbl[k].cnt});
    end
    {ifb.dcpl_req, ifb.rlse_req, ifb.issue, ifb.cmpl} = 4'b0;

    // Minimum-latency decouple with nothing in flight, then settle on release.
    ifa.dcpl_req = 1'b1;
    tick();
    ifa.dcpl_req = 1'b0;
    chk("lat_drain", {2'b0, fa()}, 8'b00100100);
    tick();
    chk("lat_dcpl", {2'b0, fa()}, 8'b00111000);
    repeat (2) tick();
    chk("lat_hold", {2'b0, fa()}, 8'b00111000);
    ifa.rlse_req = 1'b1;
    tick();
    ifa.rlse_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("settle%0d", k), {2'b0, fa()}, 8'b00110100);
      tick();
    end
    chk("settle_done", {2'b0, fa()}, 8'h00);

    // Drain three in-flight transactions, one completion every 5 cycles.
    ifa.issue = 1'b1;
    repeat (3) tick();
    ifa.issue = 1'b0;
    chk("drain_pre_cnt", ifa.outstanding, 8'd3);
    ifa.dcpl_req = 1'b1;
    tick();
    ifa.dcpl_req = 1'b0;
    tick();
    for (int j = 0; j < 3; j++) begin
      ifa.cmpl = 1'b1;
      tick();
      ifa.cmpl = 1'b0;
      chk($sformatf("drain_cnt%0d", j), ifa.outstanding, 8'(2 - j));
      if (j < 2) repeat (4) tick();
    end
    chk("drain_zero_still", {2'b0, fa()}, 8'b00100100);
    tick();
    chk("drain_dcpl", {2'b0, fa()}, 8'b00111000);
    a_release_to_idle("drain_rel");

    // Timeout: two stuck transactions, 16 drain cycles then forced decouple.
    ifa.issue = 1'b1;
    repeat (2) tick();
    ifa.issue = 1'b0;
    ifa.dcpl_req = 1'b1;
    tick();
    ifa.dcpl_req = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("to_drain%0d", k), {2'b0, fa()}, 8'b00100100);
      tick();
    end
    chk("to_dcpl", {2'b0, fa()}, 8'b00111010);
    chk("to_cnt", ifa.outstanding, 8'd0);
    ifa.rlse_req = 1'b1;
    tick();
    ifa.rlse_req = 1'b0;
    repeat (4) tick();
    chk("to_err_held", {2'b0, fa()}, 8'b00000010);
    ifa.dcpl_req = 1'b1;
    tick();
    ifa.dcpl_req = 1'b0;
    chk("to_err_clr", {2'b0, fa()}, 8'b00100100);
    tick();
    chk("to_redcpl", {2'b0, fa()}, 8'b00111000);
    a_release_to_idle("to_rel");

    // Reset asserted mid-drain with five in flight.
    ifa.issue = 1'b1;
    repeat (5) tick();
    ifa.issue = 1'b0;
    ifa.dcpl_req = 1'b1;
    tick();
    ifa.dcpl_req = 1'b0;
    tick();
    chk("mid_cnt", ifa.outstanding, 8'd5);
    chk("mid_flags", {2'b0, fa()}, 8'b00100100);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("mid_rst_flags", {2'b0, fa()}, 8'h00);
    chk("mid_rst_cnt", ifa.outstanding, 8'd0);
    tick();
    chk("mid_rst_idle", {2'b0, fa()}, 8'h00);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
